// File: rtl/async_fifo_pkg.sv
// Shared types for the async FIFO read-side stream controller.
// Holds the controller state encoding and the frame counter width.
package async_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } rdctl_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer that absorbs the FIFO read latency.
// The head entry is a register that drives the output word directly.
module stream_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [1:0]   occ_q, occ_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;

    // Next entries: a push lands in the head when it is, or becomes, free.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push && pop) begin
            if (occ_q == 2'd2) begin
                head_d = tail_q;
                tail_d = push_data;
            end else begin
                head_d = push_data;
            end
        end else if (push) begin
            if (occ_q == 2'd0) begin
                head_d = push_data;
            end else begin
                tail_d = push_data;
            end
            occ_d = occ_q + 2'd1;
        end else if (pop) begin
            if (occ_q == 2'd2) begin
                head_d = tail_q;
            end
            occ_d = occ_q - 2'd1;
        end
    end

    // Buffer registers, cleared by reset so buffered words are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule

// File: rtl/fifo_rd_stream_ctrl.sv
// Read-domain consumer of async_fifo: fetches words with credit-based
// flow control and emits them as a framed valid/ready stream.
module fifo_rd_stream_ctrl
    import async_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic                   rinc,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   fifo_empty,
    output logic                   fifo_ren,
    input  logic [FIFO_WIDTH-1:0]  fifo_dout,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [FIFO_WIDTH-1:0]  m_data,
    output logic                   m_sop,
    output logic                   m_eop,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    rdctl_state_t           state_q, state_d;
    logic                   inflight_q, inflight_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic [1:0]             occ;
    logic                   pop;
    logic [2:0]             credit;

    stream_skid_buf #(.W(FIFO_WIDTH)) u_skid (
        .clk       (rinc),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head      (m_data)
    );

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign credit  = {1'b0, occ} + {2'b00, inflight_q};

    // Next state and read enable; a pop this cycle frees one credit.
    always_comb begin
        state_d  = state_q;
        fifo_ren = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = FETCH;
            end
            FETCH: begin
                fifo_ren = !fifo_empty && (credit < 3'd2 + {2'b00, pop});
                if (!en) state_d = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    state_d = FETCH;
                end else if (occ == 2'd0 && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat position within the frame and completed-frame count.
    always_comb begin
        inflight_d = fifo_ren;
        beat_d     = beat_q;
        frame_d    = frame_q;
        if (pop) begin
            if (beat_q == LAST_BEAT) begin
                beat_d  = '0;
                frame_d = frame_q + FRAME_CNT_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    // Control registers; reset abandons any read still in flight.
    always_ff @(posedge rinc or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            frame_q    <= frame_d;
        end
    end

    assign m_sop     = m_valid && (beat_q == '0);
    assign m_eop     = m_valid && (beat_q == LAST_BEAT);
    assign frame_cnt = frame_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rd_stream_ctrl.sv
// Directed bench for fifo_rd_stream_ctrl with a behavioural FIFO source.
// A second instance with BURST_LEN=1 covers the frame counter wrap.
module tb_fifo_rd_stream_ctrl;

    localparam int BL = 16;

    logic        rinc = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [31:0] fifo_dout = '0;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_sop;
    logic        m_eop;
    logic [15:0] frame_cnt;
    logic        busy;

    logic        en1;
    logic        ready1;
    logic        empty1 = 1'b0;
    logic        ren1;
    logic [31:0] dout1 = '0;
    logic        valid1;
    logic [31:0] data1;
    logic        sop1;
    logic        eop1;
    logic [15:0] frame1;
    logic        busy1;

    int   rd_idx  = 0;
    int   rd1     = 0;
    int   n_avail = 0;
    logic flick   = 1'b0;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_idx   = 0;
    int exp_beat  = 0;
    int exp_frames = 0;

    fifo_rd_stream_ctrl #(.FIFO_WIDTH(32), .BURST_LEN(BL)) dut (
        .rinc       (rinc),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    fifo_rd_stream_ctrl #(.FIFO_WIDTH(32), .BURST_LEN(1)) dut1 (
        .rinc       (rinc),
        .rst        (rst),
        .en         (en1),
        .fifo_empty (empty1),
        .fifo_ren   (ren1),
        .fifo_dout  (dout1),
        .m_valid    (valid1),
        .m_ready    (ready1),
        .m_data     (data1),
        .m_sop      (sop1),
        .m_eop      (eop1),
        .frame_cnt  (frame1),
        .busy       (busy1)
    );

    always #5 rinc = ~rinc;

    function automatic logic [31:0] word(int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    assign fifo_empty = (rd_idx >= n_avail) || flick;

    // FIFO source: data appears one cycle after the read enable.
    always @(posedge rinc) begin
        if (fifo_ren) begin
            fifo_dout <= word(rd_idx);
            rd_idx    <= rd_idx + 1;
        end
    end

    // Never-empty source for the single-beat instance.
    always @(posedge rinc) begin
        if (ren1) begin
            dout1 <= 32'(rd1);
            rd1   <= rd1 + 1;
        end
    end

    task automatic adv();
        exp_idx++;
        if (exp_beat == BL - 1) begin
            exp_beat = 0;
            exp_frames++;
        end else begin
            exp_beat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; m_ready = 1'b0; en1 = 1'b0; ready1 = 1'b0;
        repeat (2) @(negedge rinc);
        #1;
        n_asserts++;
        if ({m_valid, m_sop, m_eop, fifo_ren, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b exp 00000",
                     {m_valid, m_sop, m_eop, fifo_ren, busy});
        end
        n_asserts++;
        if (m_data !== 32'h0 || frame_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data got data %h frames %0d exp 0 0",
                     m_data, frame_cnt);
        end
        @(negedge rinc);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int first = -1;
        int last  = -1;
        n_avail = 40;
        for (int c = 0; c < 150 && exp_idx < 40; c++) begin
            @(negedge rinc);
            en = 1'b1; m_ready = 1'b1;
            #1;
            if (m_valid && m_ready) begin
                n_asserts++;
                if (m_data !== word(exp_idx) || m_sop !== (exp_beat == 0) ||
                    m_eop !== (exp_beat == BL - 1)) begin
                    n_fail++;
                    $display("FAIL stream_word idx %0d got %h sop %b eop %b exp %h beat %0d",
                             exp_idx, m_data, m_sop, m_eop, word(exp_idx), exp_beat);
                end
                if (first < 0) first = c;
                last = c;
                adv();
            end
        end
        n_asserts++;
        if (exp_idx != 40 || last - first != 39) begin
            n_fail++;
            $display("FAIL stream_rate got %0d words in span %0d exp 40 in 39",
                     exp_idx, last - first);
        end
        @(negedge rinc);
        #1;
        n_asserts++;
        if (frame_cnt !== 16'd2 || dut.beat_q !== 4'd8) begin
            n_fail++;
            $display("FAIL stream_end got frames %0d beat %0d exp 2 8",
                     frame_cnt, dut.beat_q);
        end
    endtask

    task automatic test_backpressure();
        logic       stall = 1'b0;
        logic [31:0] pd = '0;
        logic       ps = 1'b0;
        logic       pe = 1'b0;
        n_avail = 60;
        m_ready = 1'b1;
        for (int c = 0; c < 300 && exp_idx < 60; c++) begin
            @(negedge rinc);
            en = 1'b1; m_ready = ~m_ready;
            #1;
            n_asserts++;
            if ((fifo_ren && fifo_empty) || dut.u_skid.occ_q > 2'd2) begin
                n_fail++;
                $display("FAIL bp_safety got ren %b empty %b occ %0d exp no read, occ<=2",
                         fifo_ren, fifo_empty, dut.u_skid.occ_q);
            end
            if (stall) begin
                n_asserts++;
                if (!m_valid || m_data !== pd || m_sop !== ps || m_eop !== pe) begin
                    n_fail++;
                    $display("FAIL bp_hold got v %b %h %b %b exp 1 %h %b %b",
                             m_valid, m_data, m_sop, m_eop, pd, ps, pe);
                end
            end
            if (m_valid && m_ready) begin
                n_asserts++;
                if (m_data !== word(exp_idx) || m_sop !== (exp_beat == 0) ||
                    m_eop !== (exp_beat == BL - 1)) begin
                    n_fail++;
                    $display("FAIL bp_word idx %0d got %h sop %b eop %b exp %h beat %0d",
                             exp_idx, m_data, m_sop, m_eop, word(exp_idx), exp_beat);
                end
                adv();
            end
            stall = m_valid && !m_ready;
            pd = m_data; ps = m_sop; pe = m_eop;
        end
        @(negedge rinc);
        m_ready = 1'b1;
        #1;
        n_asserts++;
        if (exp_idx != 60 || frame_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_end got words %0d frames %0d exp 60 3",
                     exp_idx, frame_cnt);
        end
    endtask

    task automatic test_empty_flicker();
        n_avail = 80;
        for (int c = 0; c < 300 && exp_idx < 80; c++) begin
            @(negedge rinc);
            en = 1'b1; m_ready = 1'b1; flick = (c % 3 == 2);
            #1;
            n_asserts++;
            if (fifo_ren && fifo_empty) begin
                n_fail++;
                $display("FAIL flick_ren got ren 1 with empty 1 exp ren 0");
            end
            if (m_valid && m_ready) begin
                n_asserts++;
                if (m_data !== word(exp_idx) || m_sop !== (exp_beat == 0) ||
                    m_eop !== (exp_beat == BL - 1)) begin
                    n_fail++;
                    $display("FAIL flick_word idx %0d got %h exp %h",
                             exp_idx, m_data, word(exp_idx));
                end
                adv();
            end
        end
        n_asserts++;
        if (exp_idx != 80) begin
            n_fail++;
            $display("FAIL flick_count got %0d exp 80", exp_idx);
        end
        @(negedge rinc);
        flick = 1'b0;
    endtask

    task automatic test_drain();
        int pops = 0;
        int rd_at_drop;
        n_avail = 100;
        for (int c = 0; c < 6; c++) begin
            @(negedge rinc);
            en = 1'b1; m_ready = 1'b0;
        end
        #1;
        n_asserts++;
        if (dut.u_skid.occ_q !== 2'd2 || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_fill got occ %0d valid %b exp 2 1",
                     dut.u_skid.occ_q, m_valid);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge rinc);
            en = 1'b0; m_ready = 1'b1;
            #1;
            if (c == 0) rd_at_drop = rd_idx;
            if (c > 0) begin
                n_asserts++;
                if (fifo_ren !== 1'b0) begin
                    n_fail++;
                    $display("FAIL drain_ren cycle %0d got 1 exp 0", c);
                end
            end
            if (m_valid && m_ready) begin
                pops++;
                n_asserts++;
                if (m_data !== word(exp_idx)) begin
                    n_fail++;
                    $display("FAIL drain_word idx %0d got %h exp %h",
                             exp_idx, m_data, word(exp_idx));
                end
                adv();
            end
        end
        n_asserts++;
        if (pops != 3 || busy !== 1'b0 || rd_idx != rd_at_drop + 1) begin
            n_fail++;
            $display("FAIL drain_end got pops %0d busy %b reads %0d exp 3 0 1",
                     pops, busy, rd_idx - rd_at_drop);
        end
        pops = 0;
        for (int c = 0; c < 10 && pops == 0; c++) begin
            @(negedge rinc);
            en = 1'b1; m_ready = 1'b1;
            #1;
            if (m_valid && m_ready) begin
                pops++;
                n_asserts++;
                if (m_data !== word(exp_idx) || m_sop !== (exp_beat == 0) ||
                    dut.beat_q !== 4'(exp_beat)) begin
                    n_fail++;
                    $display("FAIL resume_word got %h sop %b beat %0d exp %h beat %0d",
                             m_data, m_sop, dut.beat_q, word(exp_idx), exp_beat);
                end
                adv();
            end
        end
        n_asserts++;
        if (pops != 1) begin
            n_fail++;
            $display("FAIL resume_timeout got %0d pops exp 1", pops);
        end
    endtask

    task automatic test_mid_reset();
        int pops = 0;
        for (int c = 0; c < 60 && exp_beat != 5; c++) begin
            @(negedge rinc);
            en = 1'b1; m_ready = 1'b1;
            #1;
            if (m_valid && m_ready) adv();
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge rinc);
            m_ready = 1'b0;
        end
        #1;
        n_asserts++;
        if (dut.beat_q !== 4'd5 || dut.u_skid.occ_q !== 2'd2) begin
            n_fail++;
            $display("FAIL mrst_setup got beat %0d occ %0d exp 5 2",
                     dut.beat_q, dut.u_skid.occ_q);
        end
        #1;
        rst = 1'b1;
        #1;
        n_asserts++;
        if ({m_valid, m_sop, m_eop, fifo_ren, busy} !== 5'b0 ||
            m_data !== 32'h0 || frame_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL mrst_outputs got %b data %h frames %0d exp 00000 0 0",
                     {m_valid, m_sop, m_eop, fifo_ren, busy}, m_data, frame_cnt);
        end
        @(negedge rinc);
        rst = 1'b0; m_ready = 1'b1;
        exp_beat = 0; exp_frames = 0; exp_idx = rd_idx;
        for (int c = 0; c < 10 && pops == 0; c++) begin
            @(negedge rinc);
            #1;
            if (m_valid && m_ready) begin
                pops++;
                n_asserts++;
                if (m_sop !== 1'b1 || m_data !== word(exp_idx) ||
                    frame_cnt !== 16'h0) begin
                    n_fail++;
                    $display("FAIL mrst_first got sop %b %h frames %0d exp 1 %h 0",
                             m_sop, m_data, frame_cnt, word(exp_idx));
                end
                adv();
            end
        end
        n_asserts++;
        if (pops != 1) begin
            n_fail++;
            $display("FAIL mrst_timeout got %0d pops exp 1", pops);
        end
    endtask

    task automatic test_single_beat_wrap();
        int k = 0;
        for (int c = 0; c < 66000 && k < 65537; c++) begin
            @(negedge rinc);
            en1 = 1'b1; ready1 = 1'b1;
            #1;
            if (valid1 && ready1) begin
                n_asserts++;
                if (sop1 !== 1'b1 || eop1 !== 1'b1 || data1 !== 32'(k)) begin
                    n_fail++;
                    $display("FAIL wrap_word %0d got sop %b eop %b %h exp 1 1 %h",
                             k, sop1, eop1, data1, 32'(k));
                end
                k++;
            end
        end
        @(negedge rinc);
        en1 = 1'b0;
        #1;
        n_asserts++;
        if (k != 65537 || frame1 !== 16'd1) begin
            n_fail++;
            $display("FAIL wrap_frames got pops %0d frames %0d exp 65537 1",
                     k, frame1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_flicker();
        test_drain();
        test_mid_reset();
        test_single_beat_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
